// File: rtl/csa_resolver.sv
// Sequential carry-propagate resolver for a carry-save pair: result = sum + (carry << 1).
// Resolves CHUNK bits per cycle with a registered inter-chunk carry, behind valid/ready on both sides.
module csa_resolver #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int KW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
    $error("csa_resolver: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  cin_q, cin_d;
  logic [WIDTH+1:0]      res_q, res_d;
  logic [WIDTH-1:0]      s_q, s_d;
  logic [WIDTH:0]        c_q, c_d;

  logic                  accept;
  logic                  last;
  logic [CHUNK_SAFE-1:0] s_chunk;
  logic [CHUNK_SAFE-1:0] c_chunk;
  logic [CHUNK_SAFE:0]   chunk_sum;

  assign accept = (state_q == IDLE) && in_valid && !flush;
  assign last   = (k_q == K_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output decode: everything comes from registers, nothing from the inputs
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    out_result = res_q;
  end

  // Chunk select and add
  always_comb begin
    s_chunk = '0;
    c_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        s_chunk = s_q[i*CHUNK_SAFE +: CHUNK_SAFE];
        c_chunk = c_q[i*CHUNK_SAFE +: CHUNK_SAFE];
      end
    end
    chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK_SAFE{1'b0}}, cin_q};
  end

  // Control and result update
  always_comb begin
    k_d   = k_q;
    cin_d = cin_q;
    res_d = res_q;
    if (flush) begin
      k_d   = '0;
      cin_d = 1'b0;
      res_d = '0;
    end else if (accept) begin
      k_d   = '0;
      cin_d = 1'b0;
    end else if (state_q == BUSY) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (k_q == KW'(i)) begin
          res_d[i*CHUNK_SAFE +: CHUNK_SAFE] = chunk_sum[CHUNK_SAFE-1:0];
        end
      end
      cin_d = chunk_sum[CHUNK_SAFE];
      if (last) begin
        // Top two bits fold the shifted-out carry MSB with the final chunk carry.
        res_d[WIDTH]   = c_q[WIDTH] ^ chunk_sum[CHUNK_SAFE];
        res_d[WIDTH+1] = c_q[WIDTH] & chunk_sum[CHUNK_SAFE];
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      cin_q <= 1'b0;
      res_q <= '0;
    end else begin
      k_q   <= k_d;
      cin_q <= cin_d;
      res_q <= res_d;
    end
  end

  // Operand capture: only loaded on accept, so no reset needed
  always_comb begin
    s_d = accept ? in_sum : s_q;
    c_d = accept ? {in_carry, 1'b0} : c_q;
  end

  always_ff @(posedge clk) begin
    s_q <= s_d;
    c_q <= c_d;
  end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

- Sequential carry-propagate back end for the carry-save adder family.
- Accepts one redundant pair per transaction and returns the binary value `result = sum + (carry << 1)`:
  - `sum` is the XOR vector of a carry-save stage.
  - `carry` is the unshifted majority vector of that stage.
- Resolves `CHUNK` bits per cycle with a registered inter-chunk carry, trading latency for a short carry chain.
- Sits between a CSA reduction tree and downstream consumers, behind valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 8: width of the `in_sum` and `in_carry` vectors.
- `CHUNK`, default 4: bits resolved per cycle.
  - Legal only if `CHUNK >= 1` and `WIDTH % CHUNK == 0`; otherwise raise `$error` at elaboration.
  - `NCHUNK = WIDTH/CHUNK`.
- `clk  input  1`: single clock, rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `flush  input  1`: synchronous abort, returns the block to IDLE.
- `in_valid  input  1`: an input pair is presented.
- `in_ready  output  1`: the block accepts an input pair; equals `(state == IDLE)`.
- `in_sum  input  WIDTH`: sum vector.
- `in_carry  input  WIDTH`: carry vector, unshifted.
- `out_valid  output  1`: `out_result` is valid.
- `out_ready  input  1`: the consumer accepts the result.
- `out_result  output  WIDTH+2`: resolved binary sum; covers the worst case `3*(2^WIDTH-1)`.

## Operation
- Internal operands, captured at acceptance:
  - `s_ext = {2'b0, in_sum}`
  - `c_ext = {1'b0, in_carry, 1'b0}`
- State machine: IDLE, BUSY, DONE.
- IDLE
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid`: capture `s_ext`/`c_ext`, set chunk index `k=0`, clear `cin`, go to BUSY.
- BUSY (one chunk per cycle)
  - Compute `{cout, r} = s_ext[k*CHUNK +: CHUNK] + c_ext[k*CHUNK +: CHUNK] + cin`.
  - Write `r` into `out_result[k*CHUNK +: CHUNK]`, then `cin <= cout` and `k <= k+1`.
  - On the chunk with `k == NCHUNK-1`, also write:
    - `out_result[WIDTH] = c_ext[WIDTH] ^ cout`
    - `out_result[WIDTH+1] = c_ext[WIDTH] & cout`
  - After that chunk, go to DONE.
- DONE
  - `out_valid=1`; `out_result` is held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready=0`, so there is no same-cycle bypass into a new transaction.
- `flush` (any state)
  - Next state is IDLE.
  - `out_valid` drops the next cycle; `k` and `cin` clear.
  - `out_result` is cleared to 0.
  - `flush` has priority over `in_valid` and `out_ready` in the same cycle.
- Chunk index counter width is `max(1, $clog2(NCHUNK))`. It never wraps: the transition to DONE occurs at `NCHUNK-1`.
- `NCHUNK == 1` is legal; BUSY then lasts one cycle.
- Inputs are sampled only on the accept edge. Changes to `in_sum`/`in_carry` while in BUSY or DONE have no effect.

## Timing
- Reset (`rst_n` low, asynchronous), immediately:
  - state = IDLE, `out_valid=0`, `out_result=0`, `k=0`, `cin=0`.
  - `in_ready` reads 1 as soon as reset is released.
- Reset mid-transaction abandons the result; it is never presented.
- Accept on edge T (`in_valid && in_ready`).
- BUSY occupies edges T+1 … T+NCHUNK.
- `out_valid` is high from the cycle after edge T+NCHUNK, i.e. latency `NCHUNK+1` cycles from accept to `out_valid`.
- Output handshake completes on the first edge with `out_valid && out_ready`. `in_ready` is high in the following cycle.
- Minimum initiation interval is `NCHUNK+2` cycles (back-to-back input, `out_ready` tied high).
- All outputs are registered or decoded from state only. There is no combinational path from `in_*` or `out_ready` to any output.

## Test plan
- WIDTH=8, CHUNK=4; `in_sum=0xFF`, `in_carry=0xFF` accepted at T -> `out_valid` high from T+3, `out_result=0x2FD` (765 = 3×255), `in_ready=0` through DONE.
- Cross-chunk carry: `in_sum=0x08`, `in_carry=0x04` -> `out_result=0x010`. Then `in_sum=0xF0`, `in_carry=0x08` -> `0x100`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` rises. Required:
  - `out_result` is stable and `out_valid` stays 1.
  - `in_valid`=1 with a new pair is ignored (`in_ready=0`).
  - On release, the new pair is accepted one cycle after the output handshake.
- Flush: assert `flush` in the second BUSY cycle together with `in_valid` -> IDLE next cycle, `out_valid` never rises, `out_result=0`, the new pair is not captured.
- Async reset: drop `rst_n` mid-BUSY, between clock edges -> `out_valid=0` and `out_result=0` immediately. After release, `in_sum=0x0F`, `in_carry=0x00` -> `0x00F` with normal latency.
- Randomised 1000 pairs with `out_ready` toggled randomly, plus CHUNK=8 (NCHUNK=1) -> every result equals `in_sum + 2*in_carry`, latency is `NCHUNK+1`.
